// File: rtl/axil_pkg.sv
// Shared types and register map for the AXI-Lite register master.
package axil_pkg;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      EXOKAY = 2'b01,
      SLVERR = 2'b10,
      DECERR = 2'b11
   } axil_resp_e;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_REQ  = 3'd1,
      WR_RESP = 3'd2,
      RD_REQ  = 3'd3,
      RD_RESP = 3'd4,
      RSP     = 3'd5
   } axil_mst_state_e;

   localparam logic [7:0] CTRL   = 8'h00;
   localparam logic [7:0] STATUS = 8'h04;
   localparam logic [7:0] CFG_M  = 8'h08;
   localparam logic [7:0] CFG_K  = 8'h0C;
   localparam logic [7:0] CFG_N  = 8'h10;

   function automatic logic is_busy(axil_mst_state_e s);
      return s inside {WR_REQ, WR_RESP, RD_REQ, RD_RESP};
   endfunction

endpackage

// File: rtl/axil_watchdog.sv
// Wait-state watchdog: counts enabled cycles, expires on the LIMIT-th one.
module axil_watchdog #(
   parameter int unsigned LIMIT = 256
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int CW = $clog2(LIMIT + 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (en)
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign expired = en && (cnt_q == CW'(LIMIT - 1));

endmodule

// File: rtl/axil_master.sv
// AXI-Lite initiator: one local command in, one AXI-Lite transaction out.
// Optional wait-state watchdog enabled by defining AXIL_MST_TIMEOUT_EN.
module axil_master
   import axil_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 32,
   parameter int TIMEOUT_CYC = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic [1:0]        rsp_resp,
   output logic              rsp_timeout,
   output logic [ADDR_W-1:0] m_axi_awaddr,
   output logic              m_axi_awvalid,
   input  logic              m_axi_awready,
   output logic [DATA_W-1:0] m_axi_wdata,
   output logic              m_axi_wvalid,
   input  logic              m_axi_wready,
   input  logic              m_axi_bvalid,
   input  logic [1:0]        m_axi_bresp,
   output logic              m_axi_bready,
   output logic [ADDR_W-1:0] m_axi_araddr,
   output logic              m_axi_arvalid,
   input  logic              m_axi_arready,
   input  logic [DATA_W-1:0] m_axi_rdata,
   input  logic [1:0]        m_axi_rresp,
   input  logic              m_axi_rvalid,
   output logic              m_axi_rready
);

   axil_mst_state_e   state_q, state_d;
   logic              cmd_ready_q, cmd_ready_d;
   logic              awvalid_q, awvalid_d;
   logic              wvalid_q, wvalid_d;
   logic              bready_q, bready_d;
   logic              arvalid_q, arvalid_d;
   logic              rready_q, rready_d;
   logic [ADDR_W-1:0] awaddr_q, awaddr_d;
   logic [ADDR_W-1:0] araddr_q, araddr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic [1:0]        rsp_resp_q, rsp_resp_d;
   logic              rsp_timeout_q, rsp_timeout_d;
   logic              expired;

   always_comb begin
      state_d       = state_q;
      cmd_ready_d   = cmd_ready_q;
      awvalid_d     = awvalid_q;
      wvalid_d      = wvalid_q;
      bready_d      = bready_q;
      arvalid_d     = arvalid_q;
      rready_d      = rready_q;
      awaddr_d      = awaddr_q;
      araddr_d      = araddr_q;
      wdata_d       = wdata_q;
      rsp_valid_d   = rsp_valid_q;
      rsp_rdata_d   = rsp_rdata_q;
      rsp_resp_d    = rsp_resp_q;
      rsp_timeout_d = rsp_timeout_q;
      unique case (state_q)
         IDLE: begin
            cmd_ready_d = 1'b1;
            if (cmd_valid && cmd_ready_q) begin
               cmd_ready_d = 1'b0;
               if (cmd_write) begin
                  awaddr_d  = cmd_addr;
                  wdata_d   = cmd_wdata;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  state_d   = WR_REQ;
               end else begin
                  araddr_d  = cmd_addr;
                  arvalid_d = 1'b1;
                  state_d   = RD_REQ;
               end
            end
         end
         WR_REQ: begin
            // AW and W retire independently, in either order
            if (awvalid_q && m_axi_awready)
               awvalid_d = 1'b0;
            if (wvalid_q && m_axi_wready)
               wvalid_d = 1'b0;
            if (!awvalid_d && !wvalid_d) begin
               bready_d = 1'b1;
               state_d  = WR_RESP;
            end
         end
         WR_RESP: begin
            if (m_axi_bvalid) begin
               bready_d      = 1'b0;
               rsp_valid_d   = 1'b1;
               rsp_rdata_d   = '0;
               rsp_resp_d    = m_axi_bresp;
               rsp_timeout_d = 1'b0;
               state_d       = RSP;
            end
         end
         RD_REQ: begin
            if (m_axi_arready) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = RD_RESP;
            end
         end
         RD_RESP: begin
            if (m_axi_rvalid) begin
               rready_d      = 1'b0;
               rsp_valid_d   = 1'b1;
               rsp_rdata_d   = m_axi_rdata;
               rsp_resp_d    = m_axi_rresp;
               rsp_timeout_d = 1'b0;
               state_d       = RSP;
            end
         end
         RSP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               cmd_ready_d = 1'b1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      // Watchdog abort overrides whatever the bus did this cycle
      if (expired) begin
         awvalid_d     = 1'b0;
         wvalid_d      = 1'b0;
         bready_d      = 1'b0;
         arvalid_d     = 1'b0;
         rready_d      = 1'b0;
         rsp_valid_d   = 1'b1;
         rsp_rdata_d   = '0;
         rsp_resp_d    = SLVERR;
         rsp_timeout_d = 1'b1;
         state_d       = RSP;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         cmd_ready_q   <= 1'b0;
         awvalid_q     <= 1'b0;
         wvalid_q      <= 1'b0;
         bready_q      <= 1'b0;
         arvalid_q     <= 1'b0;
         rready_q      <= 1'b0;
         awaddr_q      <= '0;
         araddr_q      <= '0;
         wdata_q       <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_rdata_q   <= '0;
         rsp_resp_q    <= '0;
         rsp_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cmd_ready_q   <= cmd_ready_d;
         awvalid_q     <= awvalid_d;
         wvalid_q      <= wvalid_d;
         bready_q      <= bready_d;
         arvalid_q     <= arvalid_d;
         rready_q      <= rready_d;
         awaddr_q      <= awaddr_d;
         araddr_q      <= araddr_d;
         wdata_q       <= wdata_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_rdata_q   <= rsp_rdata_d;
         rsp_resp_q    <= rsp_resp_d;
         rsp_timeout_q <= rsp_timeout_d;
      end
   end

`ifdef AXIL_MST_TIMEOUT_EN
   logic wd_clr, wd_en;

   assign wd_en  = is_busy(state_q);
   assign wd_clr = (state_d != state_q);

   axil_watchdog #(
      .LIMIT(TIMEOUT_CYC)
   ) u_watchdog (
      .clk    (clk),
      .rst    (rst),
      .clr    (wd_clr),
      .en     (wd_en),
      .expired(expired)
   );
`else
   assign expired = 1'b0;
`endif

   assign cmd_ready     = cmd_ready_q;
   assign rsp_valid     = rsp_valid_q;
   assign rsp_rdata     = rsp_rdata_q;
   assign rsp_resp      = rsp_resp_q;
   assign rsp_timeout   = rsp_timeout_q;
   assign m_axi_awaddr  = awaddr_q;
   assign m_axi_awvalid = awvalid_q;
   assign m_axi_wdata   = wdata_q;
   assign m_axi_wvalid  = wvalid_q;
   assign m_axi_bready  = bready_q;
   assign m_axi_araddr  = araddr_q;
   assign m_axi_arvalid = arvalid_q;
   assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_axil_master.sv
// Bench for axil_master: register-file slave, reference map, scenario tasks.
module tb_axil_master;
   import axil_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr, cmd_wdata;
   logic        rsp_valid, rsp_ready, rsp_timeout;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_resp;
   logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
   logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
   logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
   logic        m_axi_rvalid, m_axi_rready;
   logic [1:0]  m_axi_bresp, m_axi_rresp;

   int n_chk = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   axil_master #(.DATA_W(32), .ADDR_W(32), .TIMEOUT_CYC(16)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
      .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid),
      .m_axi_awready(m_axi_awready),
      .m_axi_wdata(m_axi_wdata), .m_axi_wvalid(m_axi_wvalid),
      .m_axi_wready(m_axi_wready),
      .m_axi_bvalid(m_axi_bvalid), .m_axi_bresp(m_axi_bresp),
      .m_axi_bready(m_axi_bready),
      .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
      .m_axi_arready(m_axi_arready),
      .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
      .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
   );

   // ---------------- slave: 8-word register file, DECERR elsewhere
   int          aw_delay = 0, w_delay = 0;
   logic        ar_block = 1'b0, b_hold = 1'b0, mem_wipe = 1'b1;
   logic [31:0] smem [8];
   int          aw_wait, w_wait;
   logic        aw_got, w_got, bpend;
   logic [31:0] aw_a, w_d;
   logic        aw_hs, w_hs, ar_hs, have_aw, have_w;
   logic [31:0] wa, wd;

   function automatic logic s_ok(logic [31:0] a);
      return (a[31:5] == 27'd0) && (a[1:0] == 2'b00);
   endfunction

   assign m_axi_awready = m_axi_awvalid && !aw_got && (aw_wait >= aw_delay);
   assign m_axi_wready  = m_axi_wvalid && !w_got && (w_wait >= w_delay);
   assign m_axi_arready = m_axi_arvalid && !ar_block && !m_axi_rvalid;
   assign aw_hs   = m_axi_awvalid && m_axi_awready;
   assign w_hs    = m_axi_wvalid && m_axi_wready;
   assign ar_hs   = m_axi_arvalid && m_axi_arready;
   assign have_aw = aw_got || aw_hs;
   assign have_w  = w_got || w_hs;
   assign wa      = aw_got ? aw_a : m_axi_awaddr;
   assign wd      = w_got ? w_d : m_axi_wdata;

   always @(posedge clk) begin
      if (rst) begin
         aw_wait <= 0; w_wait <= 0;
         aw_got <= 1'b0; w_got <= 1'b0; bpend <= 1'b0;
         m_axi_bvalid <= 1'b0; m_axi_bresp <= 2'b00;
         m_axi_rvalid <= 1'b0; m_axi_rdata <= '0; m_axi_rresp <= 2'b00;
         if (mem_wipe)
            for (int i = 0; i < 8; i++) smem[i] <= '0;
      end else begin
         aw_wait <= (m_axi_awvalid && !aw_hs) ? aw_wait + 1 : 0;
         w_wait  <= (m_axi_wvalid && !w_hs) ? w_wait + 1 : 0;
         if (have_aw && have_w && !bpend && !m_axi_bvalid) begin
            aw_got <= 1'b0; w_got <= 1'b0; bpend <= 1'b1;
            if (s_ok(wa)) smem[wa[4:2]] <= wd;
            m_axi_bresp <= s_ok(wa) ? 2'b00 : 2'b11;
         end else begin
            if (aw_hs) begin aw_got <= 1'b1; aw_a <= m_axi_awaddr; end
            if (w_hs) begin w_got <= 1'b1; w_d <= m_axi_wdata; end
         end
         if (bpend && !b_hold) begin
            m_axi_bvalid <= 1'b1; bpend <= 1'b0;
         end
         if (m_axi_bvalid && m_axi_bready) m_axi_bvalid <= 1'b0;
         if (ar_hs) begin
            m_axi_rvalid <= 1'b1;
            m_axi_rdata  <= s_ok(m_axi_araddr) ? smem[m_axi_araddr[4:2]] : '0;
            m_axi_rresp  <= s_ok(m_axi_araddr) ? 2'b00 : 2'b11;
         end
         if (m_axi_rvalid && m_axi_rready) m_axi_rvalid <= 1'b0;
      end
   end

   // ---------------- reference: map of addresses written so far
   logic [31:0] ref_mem [int unsigned];

   task automatic ref_apply(input logic wr, input logic [31:0] a,
                            input logic [31:0] d,
                            output logic [31:0] erd, output logic [1:0] ers);
      int unsigned ua = a;
      erd = '0;
      if (ua < 32 && ua % 4 == 0) begin
         ers = 2'b00;
         if (wr) ref_mem[ua] = d;
         else if (ref_mem.exists(ua)) erd = ref_mem[ua];
      end else begin
         ers = 2'b11;
      end
   endtask

   // ---------------- command driver
   task automatic do_cmd(input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input int stall,
                         output logic [31:0] rd, output logic [1:0] rs,
                         output logic to, output int lat, output int aw_c,
                         output int w_c, output int ar_c, output int bad);
      int n;
      rd = '0; rs = '0; to = 1'b0; lat = 0;
      aw_c = 0; w_c = 0; ar_c = 0; bad = 0; n = 0;
      @(negedge clk);
      while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
      if (!cmd_ready) begin
         n_chk++;
         $display("FAIL cmd_accept: cmd_ready=%b, required 1", cmd_ready);
         return;
      end
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0; cmd_write = 1'($urandom);
      cmd_addr = $urandom; cmd_wdata = $urandom;
      do begin
         @(negedge clk);
         lat++;
         if (m_axi_awvalid) begin
            aw_c++;
            if (m_axi_awaddr !== a) bad++;
         end
         if (m_axi_wvalid) begin
            w_c++;
            if (m_axi_wdata !== d) bad++;
         end
         if (m_axi_arvalid) begin
            ar_c++;
            if (m_axi_araddr !== a) bad++;
         end
      end while (!rsp_valid && lat < 200);
      if (!rsp_valid) begin
         n_chk++;
         $display("FAIL rsp_wait: rsp_valid=%b after %0d cycles, required 1",
                  rsp_valid, lat);
         return;
      end
      rd = rsp_rdata; rs = rsp_resp; to = rsp_timeout;
      repeat (stall) begin
         @(negedge clk);
         if (rsp_valid !== 1'b1 || rsp_rdata !== rd ||
             rsp_resp !== rs || cmd_ready !== 1'b0) bad++;
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
   endtask

   // ---------------- scenarios
   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_chk++;
      if ({cmd_ready, rsp_valid, rsp_timeout} !== 3'b000)
         $display("FAIL reset_ctl: got %b, required 000",
                  {cmd_ready, rsp_valid, rsp_timeout});
      else n_pass++;
      n_chk++;
      if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid,
           m_axi_rready} !== 5'b00000)
         $display("FAIL reset_axi_hs: got %b, required 00000",
                  {m_axi_awvalid, m_axi_wvalid, m_axi_bready,
                   m_axi_arvalid, m_axi_rready});
      else n_pass++;
      n_chk++;
      if ({m_axi_awaddr, m_axi_wdata, m_axi_araddr} !== 96'd0)
         $display("FAIL reset_axi_data: got %h, required 0",
                  {m_axi_awaddr, m_axi_wdata, m_axi_araddr});
      else n_pass++;
      n_chk++;
      if ({rsp_rdata, rsp_resp} !== 34'd0)
         $display("FAIL reset_rsp: got %h, required 0", {rsp_rdata, rsp_resp});
      else n_pass++;
      mem_wipe = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      n_chk++;
      if (cmd_ready !== 1'b1)
         $display("FAIL reset_release: cmd_ready=%b, required 1", cmd_ready);
      else n_pass++;
   endtask

   task automatic test_cfg_write_read();
      logic [31:0] rd, erd;
      logic [1:0]  rs, ers;
      logic        to;
      int          lat, awc, wc, arc, bad;
      ref_apply(1'b1, 32'(CFG_M), 32'd4, erd, ers);
      do_cmd(1'b1, 32'(CFG_M), 32'd4, 0, rd, rs, to, lat, awc, wc, arc, bad);
      n_chk++;
      if (rs !== ers) $display("FAIL wr_resp: got %b, required %b", rs, ers);
      else n_pass++;
      n_chk++;
      if (rd !== 32'd0) $display("FAIL wr_rdata: got %h, required 0", rd);
      else n_pass++;
      n_chk++;
      if (lat != 4) $display("FAIL wr_latency: got %0d, required 4", lat);
      else n_pass++;
      n_chk++;
      if (smem[2] !== 32'd4)
         $display("FAIL slave_cfg_m: got %h, required 4", smem[2]);
      else n_pass++;
      ref_apply(1'b0, 32'(CFG_M), '0, erd, ers);
      do_cmd(1'b0, 32'(CFG_M), '0, 0, rd, rs, to, lat, awc, wc, arc, bad);
      n_chk++;
      if (rd !== erd) $display("FAIL rd_rdata: got %h, required %h", rd, erd);
      else n_pass++;
      n_chk++;
      if (rs !== ers) $display("FAIL rd_resp: got %b, required %b", rs, ers);
      else n_pass++;
      n_chk++;
      if (lat != 3) $display("FAIL rd_latency: got %0d, required 3", lat);
      else n_pass++;
   endtask

   task automatic test_aw_delay();
      logic [31:0] rd, erd;
      logic [1:0]  rs, ers;
      logic        to;
      int          lat, awc, wc, arc, bad;
      aw_delay = 3; w_delay = 0;
      ref_apply(1'b1, 32'(CFG_K), 32'h0000_0abc, erd, ers);
      do_cmd(1'b1, 32'(CFG_K), 32'h0000_0abc, 0,
             rd, rs, to, lat, awc, wc, arc, bad);
      aw_delay = 0;
      n_chk++;
      if (wc != 1) $display("FAIL awdly_wvalid: got %0d cycles, required 1", wc);
      else n_pass++;
      n_chk++;
      if (awc != 4)
         $display("FAIL awdly_awvalid: got %0d cycles, required 4", awc);
      else n_pass++;
      n_chk++;
      if (bad != 0)
         $display("FAIL awdly_stable: got %0d changes, required 0", bad);
      else n_pass++;
      n_chk++;
      if (rs !== ers) $display("FAIL awdly_resp: got %b, required %b", rs, ers);
      else n_pass++;
   endtask

   task automatic test_rsp_stall();
      logic [31:0] rd, erd;
      logic [1:0]  rs, ers;
      logic        to;
      int          lat, awc, wc, arc, bad;
      ref_apply(1'b1, 32'(STATUS), 32'ha5a5_0001, erd, ers);
      do_cmd(1'b1, 32'(STATUS), 32'ha5a5_0001, 0,
             rd, rs, to, lat, awc, wc, arc, bad);
      ref_apply(1'b0, 32'(STATUS), '0, erd, ers);
      do_cmd(1'b0, 32'(STATUS), '0, 5, rd, rs, to, lat, awc, wc, arc, bad);
      n_chk++;
      if (rd !== erd) $display("FAIL stall_rdata: got %h, required %h", rd, erd);
      else n_pass++;
      n_chk++;
      if (bad != 0)
         $display("FAIL stall_stable: got %0d bad cycles, required 0", bad);
      else n_pass++;
      @(negedge clk);
      n_chk++;
      if (cmd_ready !== 1'b1)
         $display("FAIL back_to_back: cmd_ready=%b, required 1", cmd_ready);
      else n_pass++;
   endtask

   task automatic test_random();
      logic [31:0] rd, erd, a, d;
      logic [1:0]  rs, ers;
      logic        to, wr;
      int          lat, awc, wc, arc, bad;
      for (int i = 0; i < 24; i++) begin
         wr = 1'($urandom);
         a = 32'($urandom_range(0, 9) * 4);
         if ($urandom_range(0, 7) == 0) a = a + 32'd1;
         d = $urandom;
         aw_delay = $urandom_range(0, 3);
         w_delay = $urandom_range(0, 3);
         ref_apply(wr, a, d, erd, ers);
         do_cmd(wr, a, d, $urandom_range(0, 3),
                rd, rs, to, lat, awc, wc, arc, bad);
         n_chk++;
         if (rd !== erd || rs !== ers)
            $display("FAIL rand_%0d: wr=%b a=%h got %h/%b, required %h/%b",
                     i, wr, a, rd, rs, erd, ers);
         else n_pass++;
         n_chk++;
         if (bad != 0)
            $display("FAIL rand_stable_%0d: got %0d, required 0", i, bad);
         else n_pass++;
      end
      aw_delay = 0; w_delay = 0;
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd, erd;
      logic [1:0]  rs, ers;
      logic        to;
      int          lat, awc, wc, arc, bad, n;
      b_hold = 1'b1;
      n = 0;
      @(negedge clk);
      while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
      cmd_valid = 1'b1; cmd_write = 1'b1;
      cmd_addr = 32'(CFG_N); cmd_wdata = 32'h1234_5678;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      ref_apply(1'b1, 32'(CFG_N), 32'h1234_5678, erd, ers);
      n = 0;
      do begin @(negedge clk); n++; end while (!m_axi_bready && n < 20);
      n_chk++;
      if (m_axi_bready !== 1'b1)
         $display("FAIL mid_wr_resp: bready=%b, required 1", m_axi_bready);
      else n_pass++;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      b_hold = 1'b0;
      n_chk++;
      if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid,
           m_axi_rready, rsp_valid, cmd_ready} !== 7'd0)
         $display("FAIL mid_reset: got %b, required 0000000",
                  {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid,
                   m_axi_rready, rsp_valid, cmd_ready});
      else n_pass++;
      @(negedge clk);
      n_chk++;
      if (cmd_ready !== 1'b1)
         $display("FAIL mid_release: cmd_ready=%b, required 1", cmd_ready);
      else n_pass++;
      ref_apply(1'b0, 32'(CFG_N), '0, erd, ers);
      do_cmd(1'b0, 32'(CFG_N), '0, 0, rd, rs, to, lat, awc, wc, arc, bad);
      n_chk++;
      if (rd !== erd || rs !== ers)
         $display("FAIL mid_readback: got %h/%b, required %h/%b",
                  rd, rs, erd, ers);
      else n_pass++;
   endtask

`ifdef AXIL_MST_TIMEOUT_EN
   task automatic test_timeout();
      logic [31:0] rd;
      logic [1:0]  rs;
      logic        to;
      int          lat, awc, wc, arc, bad;
      ar_block = 1'b1;
      do_cmd(1'b0, 32'(CTRL), '0, 0, rd, rs, to, lat, awc, wc, arc, bad);
      ar_block = 1'b0;
      n_chk++;
      if (to !== 1'b1 || rs !== 2'b10 || rd !== 32'd0)
         $display("FAIL timeout_rsp: got to=%b resp=%b rdata=%h, required 1/10/0",
                  to, rs, rd);
      else n_pass++;
      n_chk++;
      if (arc != 16)
         $display("FAIL timeout_arvalid: got %0d cycles, required 16", arc);
      else n_pass++;
      n_chk++;
      if (lat != 17)
         $display("FAIL timeout_latency: got %0d, required 17", lat);
      else n_pass++;
   endtask
`endif

   initial begin
      rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0;
      cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b0;
      test_reset();
      test_cfg_write_read();
      test_aw_delay();
      test_rsp_stall();
      test_random();
      test_reset_mid();
`ifdef AXIL_MST_TIMEOUT_EN
      test_timeout();
`endif
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
